// File: rtl/reg_writeback.sv
// Register-file writeback arbiter.
// Merges load responses and ALU results onto a single register-file write port.
// Loads always win the port. ALU results that cannot be written at once wait
// in a small in-order buffer. A per-register scoreboard tracks outstanding loads.
module reg_writeback #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_raw,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_byte_off,
    output logic        w_enabled,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // ALU result buffer storage (no reset: validity is tracked by count/pointers)
    logic [31:0]      fifo_data_mem [FIFO_DEPTH];
    logic [4:0]       fifo_rd_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             fifo_empty;
    logic             alu_keep;
    logic             enq, deq;
    logic             sel_valid;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;

    logic             w_enabled_reg;
    logic [4:0]       w_addr_reg;
    logic [31:0]      w_data_reg;
    logic [31:0]      pending_reg;
    logic [31:0]      pending_next;

    // Extract and extend the addressed byte/halfword of a load response.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [31:0] shifted;
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        shifted  = raw >> {off, 3'b000};
        byte_val = shifted[7:0];
        half_val = off[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            3'b000:  format_load = {{24{byte_val[7]}}, byte_val};
            3'b001:  format_load = {{16{half_val[15]}}, half_val};
            3'b100:  format_load = {24'h0, byte_val};
            3'b101:  format_load = {16'h0, half_val};
            default: format_load = raw;
        endcase
    endfunction

    assign fifo_empty = (count_reg == '0);
    assign alu_ready  = !rst && (count_reg < DEPTH_CNT);
    // rd=0 results are handshaken but otherwise dropped.
    assign alu_keep   = alu_valid && alu_ready && (alu_rd != 5'd0);

    // Pick this cycle's write source: load > buffer head > direct ALU.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = 5'd0;
        sel_data  = 32'd0;
        deq       = 1'b0;
        if (ld_valid) begin
            // A load owns the port even when discarded, keeping the rule simple.
            if (ld_rd != 5'd0) begin
                sel_valid = 1'b1;
                sel_addr  = ld_rd;
                sel_data  = format_load(ld_raw, ld_funct3, ld_byte_off);
            end
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_addr  = fifo_rd_mem[rd_ptr_reg];
            sel_data  = fifo_data_mem[rd_ptr_reg];
            deq       = 1'b1;
        end else if (alu_keep) begin
            sel_valid = 1'b1;
            sel_addr  = alu_rd;
            sel_data  = alu_data;
        end
        // Buffer the ALU result whenever it cannot go straight to the port,
        // so it never overtakes an older buffered result.
        enq = alu_keep && (ld_valid || !fifo_empty);
    end

    // Buffer storage write.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data_mem[wr_ptr_reg] <= alu_data;
            fifo_rd_mem[wr_ptr_reg]   <= alu_rd;
        end
    end

    // Buffer pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Scoreboard next state per register: issue sets (and wins), load response clears.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit, clr_hit;
                assign set_hit = ld_issue && (ld_issue_rd == 5'(gi));
                assign clr_hit = ld_valid && (ld_rd == 5'(gi));
                assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
            end
        end
    endgenerate

    // Register the write port and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enabled_reg <= 1'b0;
            w_addr_reg    <= 5'd0;
            w_data_reg    <= 32'd0;
            pending_reg   <= 32'd0;
        end else begin
            w_enabled_reg <= sel_valid;
            w_addr_reg    <= sel_addr;
            w_data_reg    <= sel_data;
            pending_reg   <= pending_next;
        end
    end

    assign w_enabled = w_enabled_reg;
    assign w_addr    = w_addr_reg;
    assign w_data    = w_data_reg;
    assign pending   = pending_reg;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_raw;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic        w_enabled;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_raw      (ld_raw),
        .ld_funct3   (ld_funct3),
        .ld_byte_off (ld_byte_off),
        .w_enabled   (w_enabled),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'd0;
        ld_issue    = 1'b0;
        ld_issue_rd = 5'd0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_raw      = 32'd0;
        ld_funct3   = 3'd0;
        ld_byte_off = 2'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] raw);
        ld_valid    = 1'b1;
        ld_rd       = rd;
        ld_funct3   = f3;
        ld_byte_off = off;
        ld_raw      = raw;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check_eq({tag, ".we"},   32'(w_enabled), 32'd1);
        check_eq({tag, ".addr"}, 32'(w_addr),    32'(addr));
        check_eq({tag, ".data"}, w_data,         data);
    endtask

    // Load formatting vectors: rd, funct3, byte offset, raw, expected.
    logic [4:0]  fmt_rd   [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    logic [2:0]  fmt_f3   [7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b101};
    logic [1:0]  fmt_off  [7] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] fmt_raw  [7] = '{32'h8001_0000, 32'h1234_7FFF, 32'hDEAD_BEEF, 32'hF000_0000,
                                  32'h0000_7F00, 32'hCAFE_F00D, 32'h0000_BEEF};
    logic [31:0] fmt_exp  [7] = '{32'hFFFF_8001, 32'h0000_7FFF, 32'hDEAD_BEEF, 32'h0000_00F0,
                                  32'h0000_007F, 32'hCAFE_F00D, 32'h0000_BEEF};
    logic        full_ready_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int k;
        idle_inputs();
        rst = 1'b1;
        step();
        step();

        // Reset state
        check_eq("rst.we",      32'(w_enabled), 32'd0);
        check_eq("rst.addr",    32'(w_addr),    32'd0);
        check_eq("rst.data",    w_data,         32'd0);
        check_eq("rst.pending", pending,        32'd0);
        check_eq("rst.ready",   32'(alu_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst.ready", 32'(alu_ready), 32'd1);

        // Direct ALU write
        drive_alu(5'd5, 32'h0000_1234);
        step();
        idle_inputs();
        expect_write("alu_direct", 5'd5, 32'h0000_1234);
        step();
        check_eq("alu_direct.idle", 32'(w_enabled), 32'd0);

        // Load beats ALU in the same cycle; ALU follows one cycle later
        drive_ld(5'd7, 3'b000, 2'd2, 32'h0080_0000);
        drive_alu(5'd3, 32'h0000_AAAA);
        step();
        idle_inputs();
        expect_write("ld_vs_alu.ld", 5'd7, 32'hFFFF_FF80);
        step();
        expect_write("ld_vs_alu.alu", 5'd3, 32'h0000_AAAA);
        step();
        check_eq("ld_vs_alu.idle", 32'(w_enabled), 32'd0);

        // Load formatting, back-to-back
        for (int i = 0; i < 7; i++) begin
            drive_ld(fmt_rd[i], fmt_f3[i], fmt_off[i], fmt_raw[i]);
            step();
            expect_write($sformatf("fmt%0d", i), fmt_rd[i], fmt_exp[i]);
        end
        idle_inputs();
        step();

        // Scoreboard set on issue, clear with the load write
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        step();
        idle_inputs();
        check_eq("pend9.set", pending, 32'h0000_0200);
        drive_ld(5'd9, 3'b101, 2'd2, 32'hBEEF_0000);
        step();
        idle_inputs();
        expect_write("pend9.ld", 5'd9, 32'h0000_BEEF);
        check_eq("pend9.clr", pending, 32'h0000_0000);

        // Set wins over clear on the same register
        ld_issue = 1'b1; ld_issue_rd = 5'd12;
        step();
        check_eq("pend12.set", pending, 32'h0000_1000);
        drive_ld(5'd12, 3'b010, 2'd0, 32'h0000_0055);
        step();
        idle_inputs();
        check_eq("pend12.both", pending, 32'h0000_1000);
        expect_write("pend12.ld", 5'd12, 32'h0000_0055);
        drive_ld(5'd12, 3'b010, 2'd0, 32'h0000_0066);
        step();
        idle_inputs();
        check_eq("pend12.clr", pending, 32'h0000_0000);

        // ALU write to a pending register is not held back; rd=0 is dropped
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        step();
        idle_inputs();
        check_eq("pend4.set", pending, 32'h0000_0010);
        drive_alu(5'd4, 32'h0000_0044);
        step();
        idle_inputs();
        expect_write("alu_pend4", 5'd4, 32'h0000_0044);
        check_eq("alu_pend4.pending", pending, 32'h0000_0010);
        drive_alu(5'd0, 32'h0000_FFFF);
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        #1;
        check_eq("rd0.ready", 32'(alu_ready), 32'd1);
        step();
        idle_inputs();
        check_eq("rd0.we",      32'(w_enabled), 32'd0);
        check_eq("rd0.pending", pending,        32'h0000_0010);
        drive_ld(5'd0, 3'b010, 2'd0, 32'h1111_1111);
        step();
        idle_inputs();
        check_eq("ld_rd0.we", 32'(w_enabled), 32'd0);
        drive_ld(5'd4, 3'b010, 2'd0, 32'h0000_0004);
        step();
        idle_inputs();
        expect_write("pend4.ld", 5'd4, 32'h0000_0004);
        check_eq("pend4.clr", pending, 32'h0000_0000);

        // Five loads with continuous ALU offers: buffer fills after four accepts
        k = 0;
        for (int i = 0; i < 5; i++) begin
            drive_ld(5'(20 + i), 3'b010, 2'd0, 32'(i + 1));
            drive_alu(5'(10 + k), 32'(32'h100 + k));
            #1;
            check_eq($sformatf("full%0d.ready", i), 32'(alu_ready), 32'(full_ready_exp[i]));
            if (full_ready_exp[i]) k++;
            step();
            expect_write($sformatf("full%0d.ld", i), 5'(20 + i), 32'(i + 1));
        end
        idle_inputs();
        #1;
        check_eq("full.ready_low", 32'(alu_ready), 32'd0);
        step();
        expect_write("drain0", 5'd10, 32'h0000_0100);
        // Enqueue and dequeue together while draining
        drive_alu(5'd14, 32'h0000_0104);
        #1;
        check_eq("drain.ready", 32'(alu_ready), 32'd1);
        step();
        idle_inputs();
        expect_write("drain1", 5'd11, 32'h0000_0101);
        for (int j = 2; j < 5; j++) begin
            step();
            expect_write($sformatf("drain%0d", j), 5'(10 + j), 32'(32'h100 + j));
        end
        step();
        check_eq("drain.idle", 32'(w_enabled), 32'd0);

        // Reset mid-operation with three buffered entries
        for (int i = 0; i < 3; i++) begin
            drive_ld(5'd21, 3'b010, 2'd0, 32'h0000_0021);
            drive_alu(5'(15 + i), 32'(32'h200 + i));
            if (i == 0) begin
                ld_issue = 1'b1; ld_issue_rd = 5'd25;
            end else begin
                ld_issue = 1'b0;
            end
            step();
        end
        idle_inputs();
        check_eq("prerst.pending", pending, 32'h0200_0000);
        check_eq("prerst.we",      32'(w_enabled), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst.we",      32'(w_enabled), 32'd0);
        check_eq("midrst.addr",    32'(w_addr),    32'd0);
        check_eq("midrst.data",    w_data,         32'd0);
        check_eq("midrst.pending", pending,        32'd0);
        check_eq("midrst.ready",   32'(alu_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("afterrst.ready", 32'(alu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("afterrst%0d.we", i), 32'(w_enabled), 32'd0);
        end
        drive_alu(5'd6, 32'h0000_0066);
        step();
        idle_inputs();
        expect_write("afterrst.alu", 5'd6, 32'h0000_0066);
        step();
        check_eq("afterrst.idle", 32'(w_enabled), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
